// File: rtl/mdr_div_root_core_pkg.sv
// pkg_system_mdr: shared MDR op codes, divide/root FSM states and default width.
package pkg_system_mdr;
  localparam int MDR_DW = 16;
  typedef enum logic [1:0] {OP_MULT, OP_DIV, OP_ROOT} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_DONE} mdr_dr_state_e;
endpackage

// File: rtl/mdr_trial_sub.sv
// mdr_trial_sub: combinational trial subtractor returning a-b and an a>=b flag.
module mdr_trial_sub #(
  parameter int W = 18
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         ge_o
);
  logic borrow;
  assign {borrow, diff_o} = {1'b0, a_i} - {1'b0, b_i};
  assign ge_o = !borrow;
endmodule

// File: rtl/mdr_div_root_core.sv
// mdr_div_root_core: restoring divide / integer square root, one result bit per clock.
// Define MDR_SIGNED_DIV_EN for two's-complement DIV with a sign-fix cycle.
module mdr_div_root_core
  import pkg_system_mdr::*;
#(
  parameter int DW = MDR_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  op_e           op,
  input  logic [DW-1:0] data_x,
  input  logic [DW-1:0] data_y,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] data_Y_a2,
  output logic [DW-1:0] remainder,
  output logic          error
);
  localparam int W  = DW + 2;
  localparam int H  = DW / 2;
  localparam int CW = $clog2(DW) + 1;
  mdr_dr_state_e state_q, state_d;
  logic [DW-1:0] x_q, x_d, y_q, y_d, res_q, res_d, rout_q, rout_d;
  logic [W-1:0]  rem_q, rem_d, sh, tv, diff;
  logic [H-1:0]  root_q, root_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_root_q, is_root_d, err_q, err_d, ge, last;
`ifdef MDR_SIGNED_DIV_EN
  logic          negq_q, negq_d, negr_q, negr_d;
`endif
  // DIV brings in one dividend bit per step, ROOT two radicand bits
  assign sh   = is_root_q ? {rem_q[W-3:0], x_q[DW-1:DW-2]} : {rem_q[W-2:0], x_q[DW-1]};
  assign tv   = is_root_q ? W'({root_q, 2'b01}) : W'(y_q);
  assign last = cnt_q == (is_root_q ? CW'(H - 1) : CW'(DW - 1));
  mdr_trial_sub #(.W(W)) u_sub (.a_i(sh), .b_i(tv), .diff_o(diff), .ge_o(ge));
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    is_root_d = is_root_q;
    res_d     = res_q;
    rout_d    = rout_q;
    err_d     = err_q;
`ifdef MDR_SIGNED_DIV_EN
    negq_d    = negq_q;
    negr_d    = negr_q;
`endif
    case (state_q)
      ST_IDLE: if (start && op != OP_MULT) begin
        is_root_d = op == OP_ROOT;
        x_d       = data_x;
        y_d       = data_y;
        rem_d     = '0;
        root_d    = '0;
        cnt_d     = '0;
        err_d     = op == OP_DIV && data_y == '0;
        state_d   = ST_RUN;
`ifdef MDR_SIGNED_DIV_EN
        if (op == OP_DIV) begin
          x_d    = data_x[DW-1] ? -data_x : data_x;
          y_d    = data_y[DW-1] ? -data_y : data_y;
          negq_d = data_x[DW-1] ^ data_y[DW-1];
          negr_d = data_x[DW-1];
        end
`endif
        if (err_d) begin
          res_d   = '1;
          rout_d  = data_x;
          state_d = ST_DONE;
        end
      end
      ST_RUN: begin
        cnt_d  = cnt_q + 1'b1;
        rem_d  = ge ? diff : sh;
        x_d    = is_root_q ? {x_q[DW-3:0], 2'b00} : {x_q[DW-2:0], ge};
        root_d = {root_q[H-2:0], ge};
        if (last) begin
          state_d = ST_DONE;
`ifdef MDR_SIGNED_DIV_EN
          if (!is_root_q) state_d = ST_FIX;
`endif
          if (state_d == ST_DONE) begin
            res_d  = is_root_q ? DW'(root_d) : x_d;
            rout_d = rem_d[DW-1:0];
          end
        end
      end
`ifdef MDR_SIGNED_DIV_EN
      ST_FIX: begin
        res_d   = negq_q ? -x_q : x_q;
        rout_d  = negr_q ? -rem_q[DW-1:0] : rem_q[DW-1:0];
        state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      is_root_q <= 1'b0;
      res_q     <= '0;
      rout_q    <= '0;
      err_q     <= 1'b0;
`ifdef MDR_SIGNED_DIV_EN
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      is_root_q <= is_root_d;
      res_q     <= res_d;
      rout_q    <= rout_d;
      err_q     <= err_d;
`ifdef MDR_SIGNED_DIV_EN
      negq_q    <= negq_d;
      negr_q    <= negr_d;
`endif
    end
  end
  assign busy      = state_q != ST_IDLE;
  assign done      = state_q == ST_DONE;
  assign data_Y_a2 = res_q;
  assign remainder = rout_q;
  assign error     = err_q;
endmodule

// File: tb/tb_mdr_div_root_core.sv
// tb_mdr_div_root_core: directed vector table plus handshake, abort and MULT sequences.
module tb_mdr_div_root_core;
  import pkg_system_mdr::*;
`ifdef MDR_SIGNED_DIV_EN
  localparam int DL = 18;
`else
  localparam int DL = 17;
`endif
  logic        clk = 0, rst_n = 0, start = 0, busy, done, error;
  op_e         op = OP_MULT;
  logic [15:0] data_x = 0, data_y = 0, data_Y_a2, remainder;
  int          n_cmp = 0, n_bad = 0, lat;
  bit          bok;
  typedef struct {
    op_e         o;
    logic [15:0] x, y, q, r;
    logic        e;
    int          l;
  } vec_t;
  vec_t tbl[10];
  mdr_div_root_core #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .data_x(data_x), .data_y(data_y),
    .busy(busy), .done(done), .data_Y_a2(data_Y_a2), .remainder(remainder), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input op_e o, input logic [15:0] x, input logic [15:0] y, input int inj,
                     output int l, output bit b);
    @(negedge clk);
    start = 1; op = o; data_x = x; data_y = y; l = -1; b = 1;
    for (int c = 1; c <= 40 && l < 0; c++) begin
      @(negedge clk);
      start = (c == inj);
      if (c == inj) begin op = OP_DIV; data_x = 9; data_y = 3; end
      if (!busy) b = 0;
      if (done) l = c;
    end
    start = 0;
  endtask
  initial begin
    tbl[0] = '{OP_DIV,  16'd100,   16'd7,   16'd14,    16'd2,   1'b0, DL};
    tbl[1] = '{OP_ROOT, 16'hFFFF,  16'd0,   16'd255,   16'd510, 1'b0, 9};
    tbl[2] = '{OP_ROOT, 16'd0,     16'd5,   16'd0,     16'd0,   1'b0, 9};
    tbl[3] = '{OP_DIV,  16'd5,     16'd0,   16'hFFFF,  16'd5,   1'b1, 1};
    tbl[4] = '{OP_DIV,  16'd30000, 16'd1,   16'd30000, 16'd0,   1'b0, DL};
    tbl[5] = '{OP_DIV,  16'd7,     16'd100, 16'd0,     16'd7,   1'b0, DL};
    tbl[6] = '{OP_ROOT, 16'd15,    16'd0,   16'd3,     16'd6,   1'b0, 9};
    tbl[7] = '{OP_DIV,  16'd32767, 16'd255, 16'd128,   16'd127, 1'b0, DL};
    tbl[8] = '{OP_DIV,  16'd0,     16'd0,   16'hFFFF,  16'd0,   1'b1, 1};
    tbl[9] = '{OP_ROOT, 16'd144,   16'd0,   16'd12,    16'd0,   1'b0, 9};
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_q", data_Y_a2, 0);
    chk("reset_rem", remainder, 0);
    chk("reset_err", error, 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      run(tbl[i].o, tbl[i].x, tbl[i].y, 0, lat, bok);
      chk($sformatf("v%0d_q", i), data_Y_a2, tbl[i].q);
      chk($sformatf("v%0d_rem", i), remainder, tbl[i].r);
      chk($sformatf("v%0d_err", i), error, tbl[i].e);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].l);
      chk($sformatf("v%0d_busy", i), bok, 1);
    end
    run(OP_DIV, 16'd1000, 16'd10, 5, lat, bok);
    chk("ignored_start_q", data_Y_a2, 100);
    chk("ignored_start_rem", remainder, 0);
    chk("ignored_start_latency", lat, DL);
    run(OP_DIV, 16'd9, 16'd3, 0, lat, bok);
    chk("after_done_q", data_Y_a2, 3);
    chk("after_done_latency", lat, DL);
    @(negedge clk);
    start = 1; op = OP_DIV; data_x = 16'd1000; data_y = 16'd7;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
    end
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", data_Y_a2, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_err", error, 0);
    @(negedge clk);
    rst_n = 1;
    bok = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) bok = 1;
    end
    chk("abort_no_done", bok, 0);
    run(OP_ROOT, 16'd144, 16'd0, 0, lat, bok);
    chk("post_abort_q", data_Y_a2, 12);
    chk("post_abort_rem", remainder, 0);
    chk("post_abort_latency", lat, 9);
    @(negedge clk);
    start = 1; op = OP_MULT; data_x = 16'd6; data_y = 16'd0;
    @(negedge clk);
    start = 0;
    bok = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) bok = 1;
    end
    chk("mult_no_handshake", bok, 0);
    chk("mult_q_held", data_Y_a2, 12);
    chk("mult_err_held", error, 0);
`ifdef MDR_SIGNED_DIV_EN
    run(OP_DIV, 16'hFFF9, 16'd2, 0, lat, bok);
    chk("signed_q", data_Y_a2, 16'hFFFD);
    chk("signed_rem", remainder, 16'hFFFF);
    chk("signed_latency", lat, 18);
    run(OP_DIV, 16'h8000, 16'hFFFF, 0, lat, bok);
    chk("signed_min_q", data_Y_a2, 16'h8000);
    chk("signed_min_err", error, 0);
`else
    run(OP_DIV, 16'hFFFF, 16'd1, 0, lat, bok);
    chk("max_q", data_Y_a2, 16'hFFFF);
    chk("max_rem", remainder, 0);
    chk("max_err", error, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mdr_div_root_core.md
# mdr_div_root_core

Iterative unsigned divide and integer square-root engine of the MDR system. It produces `data_Y_a2`, which the downstream operation-select mux forwards as the result value for DIV and ROOT. MULT results come from the separate multiplier path, so this core ignores MULT requests. It computes one result bit per clock using a restoring algorithm and reports completion with a start/busy/done handshake.

## Interface
- `DW`, 16: operand width; must be even and ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op`  in  `op_e`  operation (MULT/DIV/ROOT); sampled with `start`.
- `data_x`  in  DW  dividend (DIV) or radicand (ROOT).
- `data_y`  in  DW  divisor (DIV); ignored for ROOT.
- `busy`  out  1  high from the cycle after accept through the done cycle.
- `done`  out  1  one-cycle completion pulse.
- `data_Y_a2`  out  DW  quotient (DIV) or zero-extended root (ROOT).
- `remainder`  out  DW  DIV remainder, or ROOT remainder x − root².
- `error`  out  1  divide-by-zero flag; valid with `done`, held afterwards.

## Operation
- States: IDLE, RUN, DONE (plus FIX when `MDR_SIGNED_DIV_EN` is defined).
- IDLE:
  - `start`=1 with `op`=DIV or ROOT: capture operands, clear the iteration counter, go to RUN.
  - `op`=MULT, or `start`=0: stay in IDLE. No `busy`, no `done`.
- RUN, DIV:
  - Per cycle: shift the partial remainder left and bring in the next dividend MSB.
  - Trial-subtract the divisor. If non-negative, keep the difference and set quotient bit = 1; otherwise set it to 0.
  - N = DW iterations.
- RUN, ROOT:
  - Per cycle: bring in the next 2 radicand bits.
  - Trial-subtract (root<<2)|1. If non-negative, set root bit = 1.
  - N = DW/2 iterations. Partial remainder is DW/2+2 bits wide.
  - Root is zero-extended into `data_Y_a2`.
- Divide by zero (DIV with `data_y`=0 at accept):
  - Skip RUN and go directly to DONE.
  - `data_Y_a2` = all ones, `remainder` = `data_x`, `error` = 1.
- DONE: pulse `done`, update the outputs, return to IDLE.
- Outputs hold their last result until the next `done`. `error` clears on the next accepted start.
- `start` while not in IDLE is ignored; operands are not re-captured.
- Arithmetic is unsigned with no overflow for DIV/ROOT. Counter width is $clog2(DW)+1.

## Timing
- Define cycle k as the cycle in which `start` is high and is accepted.
- Normal DIV/ROOT: `done` is high in cycle k+N+1.
  - DW=16 DIV: cycle k+17.
  - DW=16 ROOT: cycle k+9.
- Divide by zero: `done` is high in cycle k+1.
- `busy` is high in cycles k+1 through the `done` cycle inclusive.
- Back-to-back: a new `start` can be accepted in the cycle after `done`.
- Reset values: `busy`=0, `done`=0, `data_Y_a2`=0, `remainder`=0, `error`=0, state = IDLE.
- Reset asserted mid-RUN: the operation is aborted immediately with no `done`. The next start after release behaves normally.

## Configuration
- `MDR_SIGNED_DIV_EN` defined: DIV treats operands as two's complement.
  - The core divides the magnitudes, then negates the quotient in a FIX cycle if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - `done` moves to cycle k+N+2.
  - −2^(DW−1) / −1 returns 0x8000 (DW=16) with `error`=0.
  - Divide by zero and ROOT are unchanged.
- Not defined: unsigned DIV only, no FIX state.

## Structure
- `pkg_system_mdr` holds:
  - `op_e`, which already exists.
  - The new state enum `mdr_dr_state_e` (IDLE, RUN, FIX, DONE).
  - The default width constant `MDR_DW` = 16.
- One sub-module, `mdr_trial_sub`: a combinational trial subtractor that returns the difference and a non-negative flag. DIV and ROOT share one instance.

## Test plan
All cases use DW=16.
- DIV 100/7 → `data_Y_a2`=14, `remainder`=2, `error`=0, `done` high in cycle k+17, `busy` high for cycles k+1..k+17.
- ROOT 65535 → `data_Y_a2`=255, `remainder`=510, `done` in cycle k+9. ROOT 0 → 0, 0.
- DIV 5/0 → `error`=1, `data_Y_a2`=0xFFFF, `remainder`=5, `done` in cycle k+1.
- DIV 1000/10, then `start` at cycle k+5 with 9/3 → the second start is ignored; result is 100, remainder 0. A subsequent 9/3 accepted after `done` yields 3.
- `rst_n` low at cycle k+6 of a DIV → all outputs 0 and no `done`. After release, ROOT 144 → 12, remainder 0.
- `start` with `op`=MULT → `busy` and `done` stay 0, and outputs are unchanged. Signed build: DIV −7/2 → quotient 0xFFFD (−3), remainder 0xFFFF (−1), `done` in cycle k+18.
